// File: rtl/dual_port_ram_sc.sv
// Single-clock true dual-port RAM with 1- or 2-stage registered reads, fixed collision policy,
// a post-reset zeroing sweep, and a registered collision flag.
// Latency: READ_LATENCY cycles from request to douta/doutb; no backpressure, one access per port per cycle.
module dual_port_ram_sc #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 4,
    parameter int READ_LATENCY   = 1,
    parameter int WR_PRIORITY    = 0,
    parameter int RDW_MODE       = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  wea,
    input  logic [ADDR_WIDTH-1:0] addra,
    input  logic [DATA_WIDTH-1:0] dina,
    output logic [DATA_WIDTH-1:0] douta,
    output logic                  valida,
    input  logic                  enb,
    input  logic                  web,
    input  logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] dinb,
    output logic [DATA_WIDTH-1:0] doutb,
    output logic                  validb,
    output logic                  collision,
    output logic                  init_done
);

    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam bit L_PRI_B    = (WR_PRIORITY != 0);
    localparam bit L_RDW_NEW  = (RDW_MODE != 0);
    localparam bit L_CLEAR    = (CLEAR_ON_RESET != 0);

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_clr_ptr;
    logic [ADDR_WIDTH-1:0] w_clr_ptr_nxt;
    logic                  w_clr_we;
    logic                  r_init_done;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    logic                  w_run;
    logic                  w_same;
    logic                  w_wr_a;
    logic                  w_wr_b;
    logic                  w_rd_a;
    logic                  w_rd_b;
    logic                  w_keep_a;
    logic                  w_keep_b;
    logic [DATA_WIDTH-1:0] w_rdat_a;
    logic [DATA_WIDTH-1:0] w_rdat_b;

    logic                  r_a1_vld;
    logic                  r_b1_vld;
    logic [DATA_WIDTH-1:0] r_a1_dat;
    logic [DATA_WIDTH-1:0] r_b1_dat;
    logic                  r_collision;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= L_CLEAR ? ST_CLEAR : ST_RUN;
            r_clr_ptr   <= '0;
            r_init_done <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clr_ptr   <= w_clr_ptr_nxt;
            r_init_done <= (w_state_nxt == ST_RUN);
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_clr_we      = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_we = 1'b1;
                if (r_clr_ptr == '1) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_clr_ptr_nxt = r_clr_ptr + ADDR_WIDTH'(1);
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

    // Ports stay closed until init_done rises, including the first cycle after reset without a sweep.
    assign w_run  = (r_state == ST_RUN) && r_init_done;
    assign w_same = (addra == addrb);
    assign w_wr_a = w_run && ena && wea;
    assign w_wr_b = w_run && enb && web;
    assign w_rd_a = w_run && ena && !wea;
    assign w_rd_b = w_run && enb && !web;

    assign w_keep_a = w_wr_a && !(w_wr_b && w_same && L_PRI_B);
    assign w_keep_b = w_wr_b && !(w_wr_a && w_same && !L_PRI_B);

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_mem[r_clr_ptr] <= '0;
            end
            if (w_keep_a) begin
                r_mem[addra] <= dina;
            end
            if (w_keep_b) begin
                r_mem[addrb] <= dinb;
            end
        end
    end

    assign w_rdat_a = (L_RDW_NEW && w_wr_b && w_same) ? dinb : r_mem[addra];
    assign w_rdat_b = (L_RDW_NEW && w_wr_a && w_same) ? dina : r_mem[addrb];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a1_vld    <= 1'b0;
            r_b1_vld    <= 1'b0;
            r_a1_dat    <= '0;
            r_b1_dat    <= '0;
            r_collision <= 1'b0;
        end else begin
            r_a1_vld    <= w_rd_a;
            r_b1_vld    <= w_rd_b;
            r_collision <= ena && enb && w_run && w_same && (wea || web);
            if (w_rd_a) begin
                r_a1_dat <= w_rdat_a;
            end
            if (w_rd_b) begin
                r_b1_dat <= w_rdat_b;
            end
        end
    end

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            assign douta  = r_a1_dat;
            assign doutb  = r_b1_dat;
            assign valida = r_a1_vld;
            assign validb = r_b1_vld;
        end else if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_a2_vld;
            logic                  r_b2_vld;
            logic [DATA_WIDTH-1:0] r_a2_dat;
            logic [DATA_WIDTH-1:0] r_b2_dat;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_a2_vld <= 1'b0;
                    r_b2_vld <= 1'b0;
                    r_a2_dat <= '0;
                    r_b2_dat <= '0;
                end else begin
                    r_a2_vld <= r_a1_vld;
                    r_b2_vld <= r_b1_vld;
                    if (r_a1_vld) begin
                        r_a2_dat <= r_a1_dat;
                    end
                    if (r_b1_vld) begin
                        r_b2_dat <= r_b1_dat;
                    end
                end
            end

            assign douta  = r_a2_dat;
            assign doutb  = r_b2_dat;
            assign valida = r_a2_vld;
            assign validb = r_b2_vld;
        end else begin : g_bad_lat
            $fatal(1, "dual_port_ram_sc: READ_LATENCY must be 1 or 2");
        end
    endgenerate

    assign collision = r_collision;
    assign init_done = r_init_done;

endmodule
